// File: rtl/wb_vmemem_bridge_pkg.sv
// Shared types and constants for the Wishbone to VMERdMem/VMEWrMem bridge.
package wb_vmemem_pkg;

  localparam int DATA_W          = 32;
  localparam int TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    ACK     = 2'd3
  } state_t;

endpackage

// File: rtl/wb_vmemem_bridge_if.sv
// Wishbone B4 classic bus bundle between a master and the bridge slave port.
interface wb_vmemem_bridge_if #(
  parameter int ADDR_W = 8
);
  import wb_vmemem_pkg::*;

  logic              cyc;
  logic              stb;
  logic              we;
  logic [ADDR_W-1:0] adr;
  logic [DATA_W-1:0] dat_w;
  logic [DATA_W-1:0] dat_r;
  logic              ack;
  logic              err;

  modport master (output cyc, stb, we, adr, dat_w, input dat_r, ack, err);
  modport slave  (input cyc, stb, we, adr, dat_w, output dat_r, ack, err);

endinterface

// File: rtl/wb_vmemem_timeout.sv
// Loadable down-counter; expired is high while the count sits at zero.
module wb_vmemem_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic Clk,
  input  logic Rst,
  input  logic load,
  input  logic dec,
  output logic expired
);

  logic [15:0] count_reg;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      count_reg <= 16'd0;
    end else if (load) begin
      count_reg <= 16'(TIMEOUT);
    end else if (dec && count_reg != 16'd0) begin
      count_reg <= count_reg - 16'd1;
    end
  end

  assign expired = (count_reg == 16'd0);

endmodule

// File: rtl/wb_vmemem_bridge.sv
// Wishbone classic slave issuing one-cycle VMERdMem/VMEWrMem strobes to a register bank.
// Define WB_VMEMEM_BRIDGE_TIMEOUT_EN to enable the done-timeout and wb_err_o.
module wb_vmemem_bridge
  import wb_vmemem_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              Clk,
  input  logic              Rst,
  wb_vmemem_bridge_if.slave wb,
  output logic [ADDR_W-1:0] VMEAddr,
  output logic [DATA_W-1:0] VMEWrData,
  output logic              VMERdMem,
  output logic              VMEWrMem,
  input  logic [DATA_W-1:0] VMERdData,
  input  logic              VMERdDone,
  input  logic              VMEWrDone
);

  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("wb_vmemem_bridge: TIMEOUT must be within 1..65535");
  end

  state_t            state_reg;
  logic              ack_reg;
  logic              err_reg;
  logic [DATA_W-1:0] dat_reg;
  logic              request;
  logic              timed_out;

  assign request = wb.cyc && wb.stb;

`ifdef WB_VMEMEM_BRIDGE_TIMEOUT_EN
  logic tmo_load;
  logic tmo_dec;

  // Only wait cycles without the matching Done count against the budget.
  assign tmo_load = (state_reg == IDLE) && request;
  assign tmo_dec  = ((state_reg == RD_WAIT) && !VMERdDone) ||
                    ((state_reg == WR_WAIT) && !VMEWrDone);

  wb_vmemem_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .Clk     (Clk),
    .Rst     (Rst),
    .load    (tmo_load),
    .dec     (tmo_dec),
    .expired (timed_out)
  );
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg <= IDLE;
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
      dat_reg   <= '0;
      VMEAddr   <= '0;
      VMEWrData <= '0;
      VMERdMem  <= 1'b0;
      VMEWrMem  <= 1'b0;
    end else begin
      VMERdMem <= 1'b0;
      VMEWrMem <= 1'b0;
      ack_reg  <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (request) begin
            VMEAddr   <= wb.adr;
            VMEWrData <= wb.dat_w;
            if (wb.we) begin
              VMEWrMem  <= 1'b1;
              state_reg <= WR_WAIT;
            end else begin
              VMERdMem  <= 1'b1;
              state_reg <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          // An abort by the master drops the transfer silently.
          if (!wb.cyc) begin
            state_reg <= IDLE;
          end else if (VMERdDone) begin
            dat_reg   <= VMERdData;
            ack_reg   <= 1'b1;
            state_reg <= ACK;
          end else if (timed_out) begin
            err_reg   <= 1'b1;
            state_reg <= ACK;
          end
        end
        WR_WAIT: begin
          if (!wb.cyc) begin
            state_reg <= IDLE;
          end else if (VMEWrDone) begin
            ack_reg   <= 1'b1;
            state_reg <= ACK;
          end else if (timed_out) begin
            err_reg   <= 1'b1;
            state_reg <= ACK;
          end
        end
        ACK: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign wb.ack   = ack_reg;
  assign wb.err   = err_reg;
  assign wb.dat_r = dat_reg;

endmodule

// File: tb/tb_wb_vmemem_bridge.sv
// Scoreboard bench for wb_vmemem_bridge driving a small behavioural register bank.
module tb_wb_vmemem_bridge;
  import wb_vmemem_pkg::*;

  localparam int ADDR_W = 8;
  localparam int TMO    = 4;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  wb_vmemem_bridge_if #(.ADDR_W(ADDR_W)) wb ();

  logic [ADDR_W-1:0] VMEAddr;
  logic [31:0]       VMEWrData;
  logic [31:0]       VMERdData;
  logic              VMERdMem;
  logic              VMEWrMem;
  logic              VMERdDone;
  logic              VMEWrDone;

  wb_vmemem_bridge #(
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TMO)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .wb        (wb),
    .VMEAddr   (VMEAddr),
    .VMEWrData (VMEWrData),
    .VMERdMem  (VMERdMem),
    .VMEWrMem  (VMEWrMem),
    .VMERdData (VMERdData),
    .VMERdDone (VMERdDone),
    .VMEWrDone (VMEWrDone)
  );

  // Bank: mode 0 = Done combinational from strobe, 1 = Done one cycle later, 2 = manual only
  int          bank_mode = 1;
  logic [31:0] bank_mem [0:255];
  logic        rd_q = 1'b0;
  logic        wr_q = 1'b0;
  logic        man_rd = 1'b0;
  logic        man_wr = 1'b0;

  always @(posedge Clk) begin
    rd_q <= VMERdMem;
    wr_q <= VMEWrMem;
    if (VMEWrMem) bank_mem[VMEAddr] <= VMEWrData;
  end

  assign VMERdData = bank_mem[VMEAddr];
  assign VMERdDone = (bank_mode == 0) ? VMERdMem : (bank_mode == 1) ? rd_q : man_rd;
  assign VMEWrDone = (bank_mode == 0) ? VMEWrMem : (bank_mode == 1) ? wr_q : man_wr;

  int edge_n = 0;
  always @(posedge Clk) edge_n++;

  typedef struct {
    bit          is_err;
    bit          we;
    logic [7:0]  adr;
    logic [31:0] wdat;
    logic [31:0] rdat;
    int          exp_edge;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          vectors     = 0;
  int          miscompares = 0;
  bit          outstanding = 1'b0;
  int          rd_strobes  = 0;
  int          wr_strobes  = 0;
  logic [31:0] last_rd     = 32'h0;

  // Monitor: strobe contents and response timing/data against the scoreboard
  always @(negedge Clk) begin
    if (!Rst) begin
      if (VMERdMem || VMEWrMem) begin
        vectors++;
        if (VMERdMem && VMEWrMem) begin
          miscompares++;
          $display("FAIL strobe_both: rd=%0b wr=%0b, required only one", VMERdMem, VMEWrMem);
        end else if (outstanding || sb.size() == 0) begin
          miscompares++;
          $display("FAIL strobe_unexpected: rd=%0b wr=%0b outstanding=%0b queued=%0d", VMERdMem, VMEWrMem, outstanding, sb.size());
        end else if (VMEAddr !== sb[0].adr || VMEWrMem !== sb[0].we ||
                     (sb[0].we && VMEWrData !== sb[0].wdat)) begin
          miscompares++;
          $display("FAIL strobe: wr=%0b adr=%h wdata=%h, required wr=%0b adr=%h wdata=%h", VMEWrMem, VMEAddr, VMEWrData, sb[0].we, sb[0].adr, sb[0].wdat);
        end
        outstanding = 1'b1;
        if (VMERdMem) rd_strobes++;
        if (VMEWrMem) wr_strobes++;
      end
      if (wb.ack || wb.err) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL resp_unexpected: ack=%0b err=%0b at edge %0d, required no response", wb.ack, wb.err, edge_n);
        end else begin
          mon_e = sb.pop_front();
          if (wb.err !== mon_e.is_err || wb.ack !== !mon_e.is_err ||
              wb.dat_r !== mon_e.rdat || edge_n != mon_e.exp_edge) begin
            miscompares++;
            $display("FAIL resp: ack=%0b err=%0b dat=%h edge=%0d, required ack=%0b err=%0b dat=%h edge=%0d", wb.ack, wb.err, wb.dat_r, edge_n, !mon_e.is_err, mon_e.is_err, mon_e.rdat, mon_e.exp_edge);
          end
        end
        outstanding = 1'b0;
      end
    end
  end

  // Present a request at a falling edge; lat counts the sampling cycle as cycle 0.
  task automatic issue(input bit we, input logic [7:0] adr, input logic [31:0] wdat,
                       input int lat, input bit is_err, input logic [31:0] rdat);
    exp_t e;
    @(negedge Clk);
    wb.cyc   = 1'b1;
    wb.stb   = 1'b1;
    wb.we    = we;
    wb.adr   = adr;
    wb.dat_w = wdat;
    e.is_err   = is_err;
    e.we       = we;
    e.adr      = adr;
    e.wdat     = wdat;
    e.rdat     = rdat;
    e.exp_edge = edge_n + lat;
    sb.push_back(e);
  endtask

  task automatic wait_resp(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clk);
      #1;
      if (wb.ack || wb.err) begin
        got = 1'b1;
        break;
      end
    end
    wb.cyc = 1'b0;
    wb.stb = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    repeat (3) @(negedge Clk);
    vectors++;
    if ({wb.ack, wb.err, wb.dat_r, VMERdMem, VMEWrMem, VMEAddr, VMEWrData} !== '0) begin
      miscompares++;
      $display("FAIL reset_values: ack=%0b err=%0b dat=%h rd=%0b wr=%0b adr=%h wdata=%h, required all 0", wb.ack, wb.err, wb.dat_r, VMERdMem, VMEWrMem, VMEAddr, VMEWrData);
    end
    Rst = 1'b0;
  endtask

  task automatic test_write();
    bit got;
    int wr0 = wr_strobes;
    int rd0 = rd_strobes;
    bank_mode = 1;
    issue(1'b1, 8'h00, 32'h0000ABCD, 3, 1'b0, last_rd);
    wait_resp(20, got);
    vectors++;
    if (!got || wr_strobes - wr0 != 1 || rd_strobes != rd0) begin
      miscompares++;
      $display("FAIL write: got=%0b wr_strobes=%0d rd_strobes=%0d, required 1 1 0", got, wr_strobes - wr0, rd_strobes - rd0);
    end
    $display("write adr=00 dat=0000ABCD done");
  endtask

  task automatic test_read();
    bit got;
    int rd0 = rd_strobes;
    bank_mode = 1;
    issue(1'b0, 8'h00, 32'h0, 3, 1'b0, 32'h0000ABCD);
    last_rd = 32'h0000ABCD;
    wait_resp(20, got);
    vectors++;
    if (!got || rd_strobes - rd0 != 1) begin
      miscompares++;
      $display("FAIL read: got=%0b rd_strobes=%0d, required 1 1", got, rd_strobes - rd0);
    end
    issue(1'b0, 8'h10, 32'h0, 3, 1'b0, 32'h12345678);
    last_rd = 32'h12345678;
    wait_resp(20, got);
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL read_preload: got=%0b, required 1", got);
    end
    $display("read adr=00 and adr=10 done");
  endtask

  task automatic test_zero_latency();
    bit got;
    bank_mode = 0;
    issue(1'b1, 8'h04, 32'h5A5A0F0F, 2, 1'b0, last_rd);
    wait_resp(20, got);
    issue(1'b0, 8'h04, 32'h0, 2, 1'b0, 32'h5A5A0F0F);
    last_rd = 32'h5A5A0F0F;
    wait_resp(20, got);
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL zero_latency: got=%0b, required 1", got);
    end
    $display("zero-latency write/read adr=04 done");
  endtask

  task automatic test_timeout();
    bit got;
    bank_mode = 2;
`ifdef WB_VMEMEM_BRIDGE_TIMEOUT_EN
    issue(1'b0, 8'h20, 32'h0, TMO + 2, 1'b1, last_rd);
    wait_resp(20, got);
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL timeout_err: got=%0b, required 1", got);
    end
`else
    issue(1'b0, 8'h20, 32'h0, TMO + 2, 1'b1, last_rd);
    wait_resp(20, got);
    vectors++;
    if (got) begin
      miscompares++;
      $display("FAIL no_timeout: got=%0b, required 0", got);
    end
    void'(sb.pop_front());
    outstanding = 1'b0;
`endif
    bank_mode = 1;
    issue(1'b0, 8'h10, 32'h0, 3, 1'b0, 32'h12345678);
    last_rd = 32'h12345678;
    wait_resp(20, got);
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL after_timeout: got=%0b, required 1", got);
    end
    $display("timeout scenario done");
  endtask

  task automatic test_abort();
    int seen = 0;
    bank_mode = 2;
    issue(1'b0, 8'h30, 32'h0, 3, 1'b0, last_rd);
    repeat (2) @(negedge Clk);
    wb.cyc = 1'b0;
    wb.stb = 1'b0;
    void'(sb.pop_front());
    outstanding = 1'b0;
    @(negedge Clk);
    man_rd = 1'b1;
    @(negedge Clk);
    man_rd = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      #1;
      if (wb.ack || wb.err) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL abort: responses=%0d, required 0", seen);
    end
    $display("abort with late done done");
  endtask

  task automatic test_reset_mid();
    bit got;
    int seen = 0;
    bank_mode = 2;
    issue(1'b0, 8'h30, 32'h0, 3, 1'b0, last_rd);
    repeat (3) @(negedge Clk);
    Rst    = 1'b1;
    wb.cyc = 1'b0;
    wb.stb = 1'b0;
    void'(sb.pop_front());
    outstanding = 1'b0;
    @(negedge Clk);
    vectors++;
    if ({wb.ack, wb.err, wb.dat_r, VMERdMem, VMEWrMem, VMEAddr, VMEWrData} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_values: ack=%0b err=%0b dat=%h rd=%0b wr=%0b adr=%h wdata=%h, required all 0", wb.ack, wb.err, wb.dat_r, VMERdMem, VMEWrMem, VMEAddr, VMEWrData);
    end
    Rst     = 1'b0;
    last_rd = 32'h0;
    man_rd  = 1'b1;
    @(negedge Clk);
    man_rd = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      #1;
      if (wb.ack || wb.err) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL reset_mid_late_done: responses=%0d, required 0", seen);
    end
    bank_mode = 1;
    issue(1'b1, 8'h08, 32'hC0FFEE11, 3, 1'b0, 32'h0);
    wait_resp(20, got);
    issue(1'b0, 8'h08, 32'h0, 3, 1'b0, 32'hC0FFEE11);
    last_rd = 32'hC0FFEE11;
    wait_resp(20, got);
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL reset_mid_recover: got=%0b, required 1", got);
    end
    $display("reset mid-read then write/read adr=08 done");
  endtask

  task automatic test_back_to_back();
    bit got = 1'b0;
    exp_t e;
    int rd0 = rd_strobes;
    bank_mode = 1;
    issue(1'b0, 8'h10, 32'h0, 3, 1'b0, 32'h12345678);
    for (int i = 0; i < 20; i++) begin
      @(negedge Clk);
      #1;
      if (wb.ack || wb.err) begin
        got = 1'b1;
        break;
      end
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL b2b_first: got=%0b, required 1", got);
    end
    // stb stays high; the ACK cycle delays the second sample by one extra cycle
    wb.adr     = 8'h00;
    e.is_err   = 1'b0;
    e.we       = 1'b0;
    e.adr      = 8'h00;
    e.wdat     = 32'h0;
    e.rdat     = 32'h0000ABCD;
    e.exp_edge = edge_n + 4;
    sb.push_back(e);
    last_rd = 32'h0000ABCD;
    wait_resp(20, got);
    vectors++;
    if (!got || rd_strobes - rd0 != 2) begin
      miscompares++;
      $display("FAIL b2b_second: got=%0b rd_strobes=%0d, required 1 2", got, rd_strobes - rd0);
    end
    repeat (3) @(negedge Clk);
    $display("back-to-back reads adr=10, adr=00 done");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) bank_mem[i] = 32'h0;
    bank_mem[8'h10] = 32'h12345678;
    wb.cyc   = 1'b0;
    wb.stb   = 1'b0;
    wb.we    = 1'b0;
    wb.adr   = '0;
    wb.dat_w = '0;
    test_reset();
    test_write();
    test_read();
    test_zero_latency();
    test_timeout();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: pending=%0d, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
